// File: rtl/sne_evt_stream_arbiter.sv
// Round-robin merge of N_IN valid/ready event streams into one registered output stream.
// A winner may keep the grant for up to MAX_BURST back-to-back events before the pointer rotates.
module sne_evt_stream_arbiter #(
    parameter int N_IN      = 4,
    parameter int EVT_W     = 32,
    parameter int MAX_BURST = 4,
    localparam int SRC_W    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [N_IN-1:0]       in_valid_i,
    output logic [N_IN-1:0]       in_ready_o,
    input  logic [N_IN*EVT_W-1:0] in_evt_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [EVT_W-1:0]      out_evt_o,
    output logic [SRC_W-1:0]      out_src_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [SRC_W:0] N_IN_W = (SRC_W + 1)'(N_IN);

    typedef enum logic {ARB, HOLD} state_t;

    state_t            state;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  held;
    logic [CNT_W-1:0]  burst_cnt;

    logic [SRC_W-1:0]  scan_start;
    logic [SRC_W-1:0]  scan_idx;
    logic [SRC_W:0]    scan_sum;
    logic [SRC_W-1:0]  winner;
    logic              held_valid;
    logic              slot_free;
    logic              load;
    logic [EVT_W-1:0]  evt_arr [N_IN];

    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
        return (idx == SRC_W'(N_IN - 1)) ? '0 : idx + 1'b1;
    endfunction

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
        assign evt_arr[gi] = in_evt_i[gi*EVT_W +: EVT_W];
    end

    assign slot_free  = ~out_valid_o | out_ready_i;
    assign held_valid = in_valid_i[held];
    // A released hold continues the scan just past the held input.
    assign scan_start = (state == HOLD) ? next_idx(held) : rr_ptr;
    // Gated by rst_ni so no handshake is offered while reset is held.
    assign load       = rst_ni & en_i & (|in_valid_i) & slot_free;
    assign busy_o     = out_valid_o | (en_i & (|in_valid_i));

    // Scan downward so the lowest offset from scan_start is the last assignment.
    always_comb begin
        scan_idx = scan_start;
        scan_sum = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            scan_sum = {1'b0, scan_start} + (SRC_W + 1)'(i);
            if (scan_sum >= N_IN_W) begin
                scan_sum = scan_sum - N_IN_W;
            end
            if (in_valid_i[scan_sum[SRC_W-1:0]]) begin
                scan_idx = scan_sum[SRC_W-1:0];
            end
        end
    end

    assign winner = (state == HOLD && held_valid) ? held : scan_idx;

    always_comb begin
        in_ready_o         = '0;
        in_ready_o[winner] = load;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ARB;
            rr_ptr      <= '0;
            held        <= '0;
            burst_cnt   <= '0;
            out_valid_o <= 1'b0;
            out_evt_o   <= '0;
            out_src_o   <= '0;
        end else begin
            if (load) begin
                out_valid_o <= 1'b1;
                out_evt_o   <= evt_arr[winner];
                out_src_o   <= winner;
            end else if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            // Arbitration state only moves in cycles where a load could happen.
            if (en_i && slot_free) begin
                if (state == HOLD && held_valid) begin
                    if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state     <= ARB;
                        rr_ptr    <= next_idx(held);
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end else begin
                    if (state == HOLD) begin
                        state     <= ARB;
                        rr_ptr    <= next_idx(held);
                        burst_cnt <= '0;
                    end
                    if (load) begin
                        if (MAX_BURST > 1) begin
                            state     <= HOLD;
                            held      <= winner;
                            burst_cnt <= CNT_W'(1);
                        end else begin
                            rr_ptr    <= next_idx(winner);
                        end
                    end
                end
            end
        end
    end

endmodule
